// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared XLEN, op codes, FSM states and operand helpers for mul_ctrl
`ifndef XLEN
`define XLEN 32
`endif

package mul_ctrl_pkg;

    localparam int XLEN = `XLEN;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // rs1 is signed for every op except MULHU
    function automatic logic [XLEN:0] ext_rs1(input logic [1:0] op, input logic [XLEN-1:0] v);
        return {(op != OP_MULHU) & v[XLEN-1], v};
    endfunction

    // rs2 is signed only for MUL and MULH
    function automatic logic [XLEN:0] ext_rs2(input logic [1:0] op, input logic [XLEN-1:0] v);
        return {~op[1] & v[XLEN-1], v};
    endfunction

    function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op, input logic [2*XLEN-1:0] p);
        return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_ctrl_mul.sv
// rtl/mul_ctrl_mul.sv - combinational signed multiplier (mul) used by mul_ctrl
module mul #(
    parameter int X_W = 33,
    parameter int Y_W = 33,
    parameter int Z_W = 66
) (
    input  logic signed [X_W-1:0] x,
    input  logic signed [Y_W-1:0] y,
    output logic signed [Z_W-1:0] z
);

    assign z = Z_W'(x) * Z_W'(y);

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - multiply controller (IDLE/CALC/DONE) around mul
// Optional product reuse when MUL_REUSE_EN is defined.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    state_t               state;
    logic [1:0]           op_q;
    logic [TAG_W-1:0]     tag_q;
    logic [XLEN:0]        a_q;
    logic [XLEN:0]        b_q;
    logic [2*XLEN+1:0]    prod_q;
    logic [2*XLEN+1:0]    z;
    logic                 out_valid_q;
    logic [XLEN:0]        a_ext;
    logic [XLEN:0]        b_ext;
    logic                 accept;
    logic                 hit;
    logic                 unused_prod_hi;

    assign a_ext = ext_rs1(in_op, in_rs1);
    assign b_ext = ext_rs2(in_op, in_rs2);

    mul #(
        .X_W(`XLEN + 1),
        .Y_W(`XLEN + 1),
        .Z_W(2 * `XLEN + 2)
    ) u_mul (
        .x(a_q),
        .y(b_q),
        .z(z)
    );

    assign in_ready = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef MUL_REUSE_EN
    logic reuse_valid;
    // a_q/b_q always hold the operands of prod_q once a CALC has completed
    assign hit = reuse_valid && (a_ext == a_q) && (b_ext == b_q);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef MUL_REUSE_EN
            reuse_valid <= 1'b0;
`endif
        end else if (flush) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
`ifdef MUL_REUSE_EN
            reuse_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_CALC: begin
                    prod_q      <= z;
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
`ifdef MUL_REUSE_EN
                    reuse_valid <= 1'b1;
`endif
                end
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q        <= in_op;
                        tag_q       <= in_tag;
                        a_q         <= a_ext;
                        b_q         <= b_ext;
                        out_valid_q <= hit;
                        state       <= hit ? ST_DONE : ST_CALC;
                    end else if ((state == ST_DONE) && out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign unused_prod_hi = ^prod_q[2*XLEN+1:2*XLEN];

    assign out_valid  = out_valid_q;
    assign out_result = out_valid_q ? sel_half(op_q, prod_q[2*XLEN-1:0]) : '0;
    assign out_tag    = out_valid_q ? tag_q : '0;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - self-checking bench for mul_ctrl (directed + random vs arithmetic model)
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int TAG_W = 5;
`ifdef MUL_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic [31:0]      in_rs1 = '0;
    logic [31:0]      in_rs2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int total = 0;
    int bad = 0;

    bit     key_valid = 1'b0;
    longint key_a = 0;
    longint key_b = 0;

    mul_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Mathematical value each operand is interpreted as; equal values mean equal products
    function automatic longint val_a(input logic [1:0] op, input logic [31:0] a);
        return (op == 2'b11) ? longint'({32'b0, a}) : longint'($signed(a));
    endfunction

    function automatic longint val_b(input logic [1:0] op, input logic [31:0] b);
        return op[1] ? longint'({32'b0, b}) : longint'($signed(b));
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit h;
        h = key_valid && (val_a(op, a) == key_a) && (val_b(op, b) == key_b);
        return (REUSE && h) ? 1 : 2;
    endfunction

    task automatic model_note(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        key_valid = 1'b1;
        key_a = val_a(op, a);
        key_b = val_b(op, b);
    endtask

    // Starts in IDLE at edge+1; returns in IDLE at edge+1
    task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag, input int stall,
                           output logic [31:0] got, output int lat);
        logic [31:0] exp;
        int          exp_l;
        exp   = ref_mul(op, a, b);
        exp_l = exp_lat(op, a, b);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        out_ready = (stall == 0);
        #1;
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        got = out_result;
        check({name, ".lat"}, 64'(lat), 64'(exp_l));
        check({name, ".res"}, 64'(out_result), 64'(exp));
        check({name, ".tag"}, 64'(out_tag), 64'(tag));
        model_note(op, a, b);
        if (stall > 0) begin
            in_valid = 1'b1; in_op = ~op; in_rs1 = ~a; in_tag = ~tag;
            for (int s = 0; s < stall; s++) begin
                check({name, ".hold_rdy"}, 64'(in_ready), 64'd0);
                check({name, ".hold_vld"}, 64'(out_valid), 64'd1);
                check({name, ".hold_res"}, 64'(out_result), 64'(exp));
                check({name, ".hold_tag"}, 64'(out_tag), 64'(tag));
                tick();
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        check({name, ".drain"}, 64'(out_valid), 64'd0);
        tick();
        check({name, ".nodup"}, 64'(out_valid), 64'd0);
        check({name, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          lat;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        logic [31:0] bq_a[4];
        logic [31:0] bq_b[4];
        int          n_got, last_cyc;
        bit          acc;

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_result", 64'(out_result), 64'd0);
        check("rst.out_tag", 64'(out_tag), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // directed arithmetic
        run_req("mul_neg", OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd3, 0, got, lat);
        check("mul_neg.const", 64'(got), 64'hFFFFFFEB);
        check("mul_neg.lat2", 64'(lat), 64'd2);
        run_req("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 5'd4, 0, got, lat);
        check("mulh_min.const", 64'(got), 64'h40000000);
        run_req("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 0, got, lat);
        check("mulhu_max.const", 64'(got), 64'hFFFFFFFE);
        run_req("mulhsu_max", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0, got, lat);
        check("mulhsu_max.const", 64'(got), 64'hFFFFFFFF);

        // backpressure: out_ready low 5 cycles in DONE
        run_req("stall", OP_MULH, 32'h7654321F, 32'hC0FFEE11, 5'd17, 5, got, lat);

        // flush during CALC
        in_valid = 1'b1; in_op = OP_MUL; in_rs1 = 32'h00001234; in_rs2 = 32'h00005678; in_tag = 5'd9;
        tick();
        in_valid = 1'b0;
        check("flush.calc_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        check("flush.in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        key_valid = 1'b0;
        check("flush.idle", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("flush.no_valid", 64'(out_valid), 64'd0);
            tick();
        end
        run_req("post_flush", OP_MULHU, 32'hDEADBEEF, 32'h01234567, 5'd10, 0, got, lat);

        // reuse sequence
        run_req("reuse_a", OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'd11, 0, got, lat);
        run_req("reuse_b", OP_MUL, 32'h12345678, 32'h9ABCDEF0, 5'd12, 0, got, lat);
`ifdef MUL_REUSE_EN
        check("reuse_b.lat1", 64'(lat), 64'd1);
`else
        check("reuse_b.lat2", 64'(lat), 64'd2);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        key_valid = 1'b0;
        run_req("reuse_c", OP_MUL, 32'h12345678, 32'h9ABCDEF0, 5'd13, 0, got, lat);
        check("reuse_c.lat2", 64'(lat), 64'd2);

        // back-to-back: one result every 2 cycles
        bq_a = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        bq_b = '{32'h00000003, 32'hFFFFFFF0, 32'h80000001, 32'h7FFFFFFF};
        n_got = 0; last_cyc = 0;
        begin
            int idx;
            idx = 0;
            in_valid = 1'b1; in_op = OP_MULH; in_rs1 = bq_a[0]; in_rs2 = bq_b[0]; in_tag = 5'd20;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 20; cyc++) begin
                #1;
                acc = in_valid && in_ready;
                tick();
                if (acc) begin
                    idx++;
                    if (idx < 4) begin
                        in_rs1 = bq_a[idx]; in_rs2 = bq_b[idx]; in_tag = 5'(20 + idx);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (out_valid && n_got < 4) begin
                    check("b2b.res", 64'(out_result), 64'(ref_mul(OP_MULH, bq_a[n_got], bq_b[n_got])));
                    check("b2b.tag", 64'(out_tag), 64'(20 + n_got));
                    if (n_got > 0) check("b2b.gap", 64'(cyc - last_cyc), 64'd2);
                    last_cyc = cyc;
                    n_got++;
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            check("b2b.count", 64'(n_got), 64'd4);
            model_note(OP_MULH, bq_a[3], bq_b[3]);
        end
        tick();

        // reset during CALC
        in_valid = 1'b1; in_op = OP_MULHU; in_rs1 = 32'hABCDEF01; in_rs2 = 32'h13579BDF; in_tag = 5'd30;
        tick();
        in_valid = 1'b0;
        check("rstcalc.busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstcalc.busy0", 64'(busy), 64'd0);
        check("rstcalc.valid0", 64'(out_valid), 64'd0);
        check("rstcalc.res0", 64'(out_result), 64'd0);
        check("rstcalc.tag0", 64'(out_tag), 64'd0);
        tick();
        rst_n = 1'b1;
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstcalc.no_result", 64'(out_valid), 64'd0);
        end

        // reset while a result is waiting in DONE
        in_valid = 1'b1; in_op = OP_MUL; in_rs1 = 32'h00000101; in_rs2 = 32'h00000202; in_tag = 5'd31;
        tick();
        in_valid = 1'b0;
        tick();
        check("rstdone.valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstdone.valid0", 64'(out_valid), 64'd0);
        check("rstdone.res0", 64'(out_result), 64'd0);
        check("rstdone.tag0", 64'(out_tag), 64'd0);
        tick();
        rst_n = 1'b1;
        key_valid = 1'b0;
        tick();

        // random requests against the model, with occasional operand repeats
        r_a = 32'd0; r_b = 32'd0;
        for (int i = 0; i < 30; i++) begin
            r_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 || i == 0) begin
                case ($urandom_range(0, 4))
                    0:       r_a = 32'h80000000;
                    1:       r_a = 32'hFFFFFFFF;
                    default: r_a = $urandom;
                endcase
                r_b = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            end
            run_req("rand", r_op, r_a, r_b, 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 2)), got, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
